// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - 16-entry out-of-order issue queue with tag wakeup and dense age ordering.
// Optional macro IQ_FLUSH_EN adds a synchronous flush input that empties the queue.
module issue_queue #(
  parameter int OPCODE_WIDTH  = 7,
  parameter int AGE_WIDTH     = 5,
  parameter int TAG_WIDTH     = 6,
  parameter int PAYLOAD_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef IQ_FLUSH_EN
  input  logic                        flush,
`endif
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic [OPCODE_WIDTH-1:0]     disp_op,
  input  logic [TAG_WIDTH-1:0]        disp_src1_tag,
  input  logic [TAG_WIDTH-1:0]        disp_src2_tag,
  input  logic                        disp_src1_rdy,
  input  logic                        disp_src2_rdy,
  input  logic [PAYLOAD_WIDTH-1:0]    disp_payload,
  input  logic                        wk_valid,
  input  logic [TAG_WIDTH-1:0]        wk_tag,
  output logic [16*OPCODE_WIDTH-1:0]  arb_op,
  output logic [15:0]                 arb_req,
  output logic [16*AGE_WIDTH-1:0]     arb_age,
  input  logic                        arb_grant,
  input  logic [3:0]                  arb_addr,
  output logic                        iss_valid,
  output logic [OPCODE_WIDTH-1:0]     iss_op,
  output logic [PAYLOAD_WIDTH-1:0]    iss_payload,
  output logic [4:0]                  count
);

  localparam int N = 16;

  logic [N-1:0]             valid_q, valid_d;
  logic [N-1:0]             src1_rdy_q, src1_rdy_d;
  logic [N-1:0]             src2_rdy_q, src2_rdy_d;
  logic [OPCODE_WIDTH-1:0]  op_q [N];
  logic [OPCODE_WIDTH-1:0]  op_d [N];
  logic [TAG_WIDTH-1:0]     src1_tag_q [N];
  logic [TAG_WIDTH-1:0]     src1_tag_d [N];
  logic [TAG_WIDTH-1:0]     src2_tag_q [N];
  logic [TAG_WIDTH-1:0]     src2_tag_d [N];
  logic [AGE_WIDTH-1:0]     age_q [N];
  logic [AGE_WIDTH-1:0]     age_d [N];
  logic [PAYLOAD_WIDTH-1:0] payload_q [N];
  logic [PAYLOAD_WIDTH-1:0] payload_d [N];
  logic [4:0]               count_q, count_d;
  logic                     iss_valid_q, iss_valid_d;
  logic [OPCODE_WIDTH-1:0]  iss_op_q, iss_op_d;
  logic [PAYLOAD_WIDTH-1:0] iss_payload_q, iss_payload_d;

  logic [N-1:0]             entry_req;
  logic                     issue;
  logic                     dispatch;
  logic [3:0]               free_idx;
  logic [AGE_WIDTH-1:0]     issue_age;

  assign entry_req  = valid_q & src1_rdy_q & src2_rdy_q;
  assign disp_ready = (count_q < 5'd16);
  assign issue      = arb_grant & valid_q[arb_addr] & entry_req[arb_addr];
  assign dispatch   = disp_valid & disp_ready;
  assign issue_age  = age_q[arb_addr];

  always_comb begin
    free_idx = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = 4'(i);
    end
  end

  always_comb begin
    arb_op  = '0;
    arb_age = '0;
    for (int i = 0; i < N; i++) begin
      if (valid_q[i]) begin
        arb_op[i*OPCODE_WIDTH +: OPCODE_WIDTH] = op_q[i];
        arb_age[i*AGE_WIDTH +: AGE_WIDTH]      = age_q[i];
      end
    end
  end
  assign arb_req = entry_req;

  always_comb begin
    valid_d       = valid_q;
    src1_rdy_d    = src1_rdy_q;
    src2_rdy_d    = src2_rdy_q;
    op_d          = op_q;
    src1_tag_d    = src1_tag_q;
    src2_tag_d    = src2_tag_q;
    age_d         = age_q;
    payload_d     = payload_q;
    count_d       = count_q + 5'(dispatch) - 5'(issue);
    iss_valid_d   = issue;
    iss_op_d      = issue ? op_q[arb_addr] : '0;
    iss_payload_d = issue ? payload_q[arb_addr] : '0;

    for (int i = 0; i < N; i++) begin
      if (wk_valid && valid_q[i]) begin
        if (src1_tag_q[i] == wk_tag) src1_rdy_d[i] = 1'b1;
        if (src2_tag_q[i] == wk_tag) src2_rdy_d[i] = 1'b1;
      end
      // Close the age gap left by the issuing entry so ages stay dense.
      if (issue && valid_q[i] && (age_q[i] > issue_age)) age_d[i] = age_q[i] - 1'b1;
    end

    if (issue) valid_d[arb_addr] = 1'b0;

    // Free slot comes from registered valid, so a slot freed this cycle is not reused yet.
    if (dispatch) begin
      valid_d[free_idx]    = 1'b1;
      op_d[free_idx]       = disp_op;
      src1_tag_d[free_idx] = disp_src1_tag;
      src2_tag_d[free_idx] = disp_src2_tag;
      src1_rdy_d[free_idx] = disp_src1_rdy | (wk_valid && (disp_src1_tag == wk_tag));
      src2_rdy_d[free_idx] = disp_src2_rdy | (wk_valid && (disp_src2_tag == wk_tag));
      age_d[free_idx]      = AGE_WIDTH'(count_q - 5'(issue));
      payload_d[free_idx]  = disp_payload;
    end

`ifdef IQ_FLUSH_EN
    if (flush) begin
      valid_d       = '0;
      count_d       = '0;
      iss_valid_d   = 1'b0;
      iss_op_d      = '0;
      iss_payload_d = '0;
      for (int i = 0; i < N; i++) age_d[i] = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      src1_rdy_q    <= '0;
      src2_rdy_q    <= '0;
      count_q       <= '0;
      iss_valid_q   <= 1'b0;
      iss_op_q      <= '0;
      iss_payload_q <= '0;
      for (int i = 0; i < N; i++) begin
        op_q[i]       <= '0;
        src1_tag_q[i] <= '0;
        src2_tag_q[i] <= '0;
        age_q[i]      <= '0;
        payload_q[i]  <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      src1_rdy_q    <= src1_rdy_d;
      src2_rdy_q    <= src2_rdy_d;
      count_q       <= count_d;
      iss_valid_q   <= iss_valid_d;
      iss_op_q      <= iss_op_d;
      iss_payload_q <= iss_payload_d;
      op_q          <= op_d;
      src1_tag_q    <= src1_tag_d;
      src2_tag_q    <= src2_tag_d;
      age_q         <= age_d;
      payload_q     <= payload_d;
    end
  end

  assign count       = count_q;
  assign iss_valid   = iss_valid_q;
  assign iss_op      = iss_op_q;
  assign iss_payload = iss_payload_q;

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - directed self-checking bench for issue_queue.
module tb_issue_queue;
  localparam int OW = 7;
  localparam int AW = 5;
  localparam int TW = 6;
  localparam int PW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            disp_valid = 1'b0;
  logic            disp_ready;
  logic [OW-1:0]   disp_op = '0;
  logic [TW-1:0]   disp_src1_tag = '0;
  logic [TW-1:0]   disp_src2_tag = '0;
  logic            disp_src1_rdy = 1'b0;
  logic            disp_src2_rdy = 1'b0;
  logic [PW-1:0]   disp_payload = '0;
  logic            wk_valid = 1'b0;
  logic [TW-1:0]   wk_tag = '0;
  logic [16*OW-1:0] arb_op;
  logic [15:0]     arb_req;
  logic [16*AW-1:0] arb_age;
  logic            arb_grant = 1'b0;
  logic [3:0]      arb_addr = '0;
  logic            iss_valid;
  logic [OW-1:0]   iss_op;
  logic [PW-1:0]   iss_payload;
  logic [4:0]      count;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [16*AW-1:0] exp_age;

  issue_queue #(.OPCODE_WIDTH(OW), .AGE_WIDTH(AW), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)) dut (
    .clk(clk), .rst(rst),
`ifdef IQ_FLUSH_EN
    .flush(flush),
`endif
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_payload(disp_payload), .wk_valid(wk_valid), .wk_tag(wk_tag),
    .arb_op(arb_op), .arb_req(arb_req), .arb_age(arb_age),
    .arb_grant(arb_grant), .arb_addr(arb_addr),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_payload(iss_payload), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] age_of(input int i);
    return arb_age[i*AW +: AW];
  endfunction

  function automatic logic [OW-1:0] op_of(input int i);
    return arb_op[i*OW +: OW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input int op, input int t1, input logic r1, input int t2, input logic r2,
                      input logic [PW-1:0] pl);
    disp_valid    = 1'b1;
    disp_op       = OW'(op);
    disp_src1_tag = TW'(t1);
    disp_src1_rdy = r1;
    disp_src2_tag = TW'(t2);
    disp_src2_rdy = r2;
    disp_payload  = pl;
    tick();
    disp_valid    = 1'b0;
  endtask

  initial begin
    tick();
    check("rst_count", 128'(count), 128'd0);
    check("rst_disp_ready", 128'(disp_ready), 128'd1);
    check("rst_arb_req", 128'(arb_req), 128'd0);
    check("rst_arb_op", 128'(arb_op), 128'd0);
    check("rst_arb_age", 128'(arb_age), 128'd0);
    check("rst_iss_valid", 128'(iss_valid), 128'd0);
    check("rst_iss_op", 128'(iss_op), 128'd0);
    check("rst_iss_payload", 128'(iss_payload), 128'd0);
    rst = 1'b0;

    disp(1, 0, 1, 0, 1, 64'd100);
    disp(2, 0, 1, 0, 1, 64'd101);
    disp(3, 0, 1, 0, 1, 64'd102);
    check("d3_count", 128'(count), 128'd3);
    check("d3_req", 128'(arb_req), 128'h0007);
    check("d3_age0", 128'(age_of(0)), 128'd0);
    check("d3_age1", 128'(age_of(1)), 128'd1);
    check("d3_age2", 128'(age_of(2)), 128'd2);
    check("d3_op1", 128'(op_of(1)), 128'd2);

    arb_grant = 1'b1; arb_addr = 4'd1;
    tick();
    arb_grant = 1'b0;
    check("g1_iss_valid", 128'(iss_valid), 128'd1);
    check("g1_iss_payload", 128'(iss_payload), 128'd101);
    check("g1_iss_op", 128'(iss_op), 128'd2);
    check("g1_age2", 128'(age_of(2)), 128'd1);
    check("g1_age0", 128'(age_of(0)), 128'd0);
    check("g1_count", 128'(count), 128'd2);
    check("g1_req", 128'(arb_req), 128'h0005);
    tick();
    check("g1_iss_drop", 128'(iss_valid), 128'd0);

    disp(4, 9, 1'b0, 0, 1'b1, 64'd103);
    check("wk_late_req0", 128'(arb_req), 128'h0005);
    check("wk_late_age1", 128'(age_of(1)), 128'd2);
    tick();
    check("wk_late_req1", 128'(arb_req), 128'h0005);
    wk_valid = 1'b1; wk_tag = 6'd9;
    tick();
    wk_valid = 1'b0;
    check("wk_late_req2", 128'(arb_req), 128'h0007);

    wk_valid = 1'b1; wk_tag = 6'd12;
    disp(5, 0, 1'b1, 12, 1'b0, 64'd104);
    wk_valid = 1'b0;
    check("wk_same_req", 128'(arb_req), 128'h000F);
    check("wk_same_age3", 128'(age_of(3)), 128'd3);

    wk_valid = 1'b1; wk_tag = 6'd21;
    disp(6, 20, 1'b0, 0, 1'b1, 64'd105);
    wk_valid = 1'b0;
    check("wk_miss_req", 128'(arb_req), 128'h000F);
    wk_valid = 1'b1; wk_tag = 6'd20;
    tick();
    wk_valid = 1'b0;
    check("wk_hit_req", 128'(arb_req), 128'h001F);
    check("wk_hit_count", 128'(count), 128'd5);

    disp(7, 30, 1'b0, 0, 1'b1, 64'd106);
    check("nr_count", 128'(count), 128'd6);
    arb_grant = 1'b1; arb_addr = 4'd5;
    tick();
    check("g_notready_iss", 128'(iss_valid), 128'd0);
    check("g_notready_count", 128'(count), 128'd6);
    arb_addr = 4'd10;
    tick();
    arb_grant = 1'b0;
    exp_age = '0;
    exp_age[1*AW +: AW] = 5'd2;
    exp_age[2*AW +: AW] = 5'd1;
    exp_age[3*AW +: AW] = 5'd3;
    exp_age[4*AW +: AW] = 5'd4;
    exp_age[5*AW +: AW] = 5'd5;
    check("g_invalid_iss", 128'(iss_valid), 128'd0);
    check("g_invalid_count", 128'(count), 128'd6);
    check("g_invalid_ages", 128'(arb_age), 128'(exp_age));

    arb_grant = 1'b1; arb_addr = 4'd0;
    tick();
    arb_grant = 1'b0;
    check("g0_iss_payload", 128'(iss_payload), 128'd100);
    check("g0_count", 128'(count), 128'd5);
    check("g0_age2", 128'(age_of(2)), 128'd0);
    check("g0_age5", 128'(age_of(5)), 128'd4);

    rst = 1'b1;
    #2;
    check("arst_count", 128'(count), 128'd0);
    check("arst_req", 128'(arb_req), 128'd0);
    check("arst_age", 128'(arb_age), 128'd0);
    check("arst_op", 128'(arb_op), 128'd0);
    check("arst_iss_valid", 128'(iss_valid), 128'd0);
    check("arst_iss_payload", 128'(iss_payload), 128'd0);
    check("arst_disp_ready", 128'(disp_ready), 128'd1);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) disp(i, 0, 1'b1, 0, 1'b1, 64'(200 + i));
    check("full_count", 128'(count), 128'd16);
    check("full_ready", 128'(disp_ready), 128'd0);
    check("full_req", 128'(arb_req), 128'hFFFF);
    check("full_age15", 128'(age_of(15)), 128'd15);

    disp_valid = 1'b1; disp_op = 7'd77; disp_payload = 64'd999;
    disp_src1_rdy = 1'b1; disp_src2_rdy = 1'b1;
    arb_grant = 1'b1; arb_addr = 4'd4;
    tick();
    arb_grant = 1'b0;
    check("fg_iss_payload", 128'(iss_payload), 128'd204);
    check("fg_count", 128'(count), 128'd15);
    check("fg_ready", 128'(disp_ready), 128'd1);
    check("fg_req", 128'(arb_req), 128'hFFEF);
    check("fg_age15", 128'(age_of(15)), 128'd14);
    tick();
    disp_valid = 1'b0;
    check("refill_count", 128'(count), 128'd16);
    check("refill_req", 128'(arb_req), 128'hFFFF);
    check("refill_age4", 128'(age_of(4)), 128'd15);
    check("refill_op4", 128'(op_of(4)), 128'd77);

    arb_grant = 1'b1; arb_addr = 4'd0;
    tick();
    check("g00_iss_payload", 128'(iss_payload), 128'd200);
    check("g00_count", 128'(count), 128'd15);
    disp_valid = 1'b1; disp_op = 7'd66; disp_payload = 64'd888;
    arb_addr = 4'd1;
    tick();
    arb_grant = 1'b0; disp_valid = 1'b0;
    check("sim_iss_payload", 128'(iss_payload), 128'd201);
    check("sim_count", 128'(count), 128'd15);
    check("sim_age0", 128'(age_of(0)), 128'd14);
    check("sim_age4", 128'(age_of(4)), 128'd13);
    check("sim_op0", 128'(op_of(0)), 128'd66);
    check("sim_req", 128'(arb_req), 128'hFFFD);

`ifdef IQ_FLUSH_EN
    flush = 1'b1; disp_valid = 1'b1; arb_grant = 1'b1; arb_addr = 4'd2;
    tick();
    flush = 1'b0; disp_valid = 1'b0; arb_grant = 1'b0;
    check("flush_count", 128'(count), 128'd0);
    check("flush_req", 128'(arb_req), 128'd0);
    check("flush_iss_valid", 128'(iss_valid), 128'd0);
    check("flush_age", 128'(arb_age), 128'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- 16-entry out-of-order issue queue for the RV64 core; sits directly upstream of the age-based select arbiter.
- Accepts one dispatched instruction per cycle and tracks source-operand readiness via a tag wakeup bus.
- Presents per-entry opcode, request and age vectors to the arbiter, and retires the granted entry.
- Emits the granted instruction's payload one cycle later to the execute stage.

Parameters:
- OPCODE_WIDTH, 7, opcode field width; must match the arbiter.
- AGE_WIDTH, 5, age field width; must match the arbiter.
- TAG_WIDTH, 6, physical register tag width.
- PAYLOAD_WIDTH, 64, opaque per-instruction payload width (operands, imm, dest tag).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept a dispatch this cycle.
- disp_op  in  OPCODE_WIDTH  opcode.
- disp_src1_tag / disp_src2_tag  in  TAG_WIDTH each  source tags.
- disp_src1_rdy / disp_src2_rdy  in  1 each  source already available.
- disp_payload  in  PAYLOAD_WIDTH  payload.
- wk_valid  in  1  wakeup broadcast valid.
- wk_tag  in  TAG_WIDTH  tag being produced.
- arb_op  out  16*OPCODE_WIDTH  entry i opcode at bits [i*OPCODE_WIDTH +: OPCODE_WIDTH].
- arb_req  out  16  entry valid and both sources ready.
- arb_age  out  16*AGE_WIDTH  entry age; 0 = oldest.
- arb_grant  in  1  arbiter granted an entry.
- arb_addr  in  4  granted entry index.
- iss_valid  out  1  issued instruction valid (registered).
- iss_op  out  OPCODE_WIDTH  issued opcode.
- iss_payload  out  PAYLOAD_WIDTH  issued payload.
- count  out  5  number of valid entries, 0..16.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset clears all valid bits, ages, ready bits and payload storage. Reset values: count=0, disp_ready=1, arb_req=0, arb_op=0, arb_age=0, iss_valid=0, iss_op=0, iss_payload=0. Reset mid-operation drops all entries with no issue.
- Per-entry storage: valid, op, src1/2 tag, src1/2 rdy, age, payload. Invalid entries drive arb_req=0, arb_op=0, arb_age=0.
- Dispatch:
  - disp_ready = (count < 16), derived from registered state only. A grant in the same cycle does not make a full queue ready.
  - Transfer happens when disp_valid & disp_ready. It writes the lowest-index invalid entry.
- Wakeup:
  - When wk_valid, every valid entry with srcN_tag == wk_tag sets srcN_rdy.
  - The entry being dispatched in the same cycle also compares against wk_tag; rdy = disp_srcN_rdy | match.
  - A newly written entry may request no earlier than the following cycle.
- Age (unique, dense, 0..count-1):
  - Issue: an accepted grant invalidates entry arb_addr at the clock edge. Every valid entry whose age is greater than the issued age decrements by 1.
  - Dispatch: the new entry's age = count, or count-1 if an accepted issue occurs in the same cycle.
  - Ages never wrap and never exceed 15.
- Grant acceptance:
  - A grant is accepted only if arb_grant & valid[arb_addr] & req[arb_addr].
  - A grant to an invalid or non-ready entry is ignored: no state change, iss_valid=0.
- Issue output latency is 1 cycle: iss_valid, iss_op and iss_payload are registered from the accepted entry at the grant edge. iss_valid=0 in any cycle after no accepted grant.
- count update: count_next = count + dispatch - issue. Simultaneous dispatch and issue leaves count unchanged.
- The freed slot is reusable by a dispatch no earlier than the next cycle.

Optional Feature:
- Macro: IQ_FLUSH_EN.
- When defined: adds input port flush (1 bit). flush=1 at a clock edge invalidates all entries, sets count=0, iss_valid=0, and ignores same-cycle dispatch and grant. flush has priority over everything except rst.
- When undefined: no flush port and no flush logic.

Test Plan:
- Reset, then dispatch 3 entries, all sources ready -> ages 0,1,2 in entries 0,1,2; arb_req=16'h0007; count=3.
- Grant addr=1 -> next cycle iss_valid=1 with entry 1's payload; entry 2 age becomes 1; entry 0 age stays 0; count=2.
- Dispatch with src1_rdy=0, tag=6'd9; wk_tag=9 arrives two cycles later -> arb_req bit set the cycle after the wakeup. Repeat with wakeup in the dispatch cycle -> req set the next cycle.
- Fill 16 entries -> disp_ready=0, count=16. Grant plus disp_valid in the same cycle -> no dispatch; the next cycle dispatch succeeds into the freed index with age 15.
- Grant to an invalid entry index -> iss_valid stays 0; count and ages unchanged.
- Assert rst mid-stream with 5 entries valid -> all outputs return to reset values asynchronously. With IQ_FLUSH_EN, a flush pulse gives the same result at the clock edge.
